// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store port between the core datapath and a synchronous single-port
// 32-bit word SRAM with 1-cycle read latency. Captures a request on req_valid && req_ready,
// checks alignment/legality, performs loads with lane extraction and sign/zero extension,
// and performs sub-word stores by read-modify-write or, when LSU_BYTE_STROBE_EN is defined,
// by byte strobes in a single write cycle.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; ready only while idle
//   MemRead/MemWrite      load / store request (exactly one must be set)
//   Store_Type            00 SW, 01 SH, 10 SB, 11 illegal
//   Load_Type             000 LW, 001 LH, 011 LB, 010 LHU, 100 LBU, others illegal
//   addr, wdata           byte address, store data
//   rsp_valid             one-cycle completion pulse
//   rdata                 formatted load data (0 unless a good load completes)
//   access_err            with rsp_valid: misaligned or illegal request
//   mem_en/mem_we         SRAM enable / write
//   mem_addr/mem_wdata    SRAM word address / write data
//   mem_rdata             SRAM read data, valid the cycle after a read enable
//   mem_be                byte strobes (only with LSU_BYTE_STROBE_EN)
module lsu_mem_port #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        Store_Type,
  input  logic [2:0]        Load_Type,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       rdata,
  output logic              access_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef LSU_BYTE_STROBE_EN
  ,
  output logic [3:0]        mem_be
`endif
);

  typedef enum logic [2:0] {
    StIdle, StErr, StLdRd, StLdData, StRmwRd, StRmwMerge, StWr
  } state_e;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  state_e              state_q, state_d;
  size_e               size_q, req_size;
  logic                sext_q, req_sext;
  logic [1:0]          off_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [31:0]         wdata_q;
  logic                type_ok, misaligned, req_err, accept;

  // Address bits above the SRAM window are ignored by design.
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_W+2];

  assign accept = req_valid && (state_q == StIdle);

  // Request decode: access size, signedness and error detection.
  always_comb begin
    req_size = SzWord;
    req_sext = 1'b0;
    type_ok  = 1'b1;
    if (MemRead) begin
      case (Load_Type)
        3'b000:  req_size = SzWord;
        3'b001:  begin req_size = SzHalf; req_sext = 1'b1; end
        3'b010:  req_size = SzHalf;
        3'b011:  begin req_size = SzByte; req_sext = 1'b1; end
        3'b100:  req_size = SzByte;
        default: type_ok = 1'b0;
      endcase
    end else begin
      case (Store_Type)
        2'b00:   req_size = SzWord;
        2'b01:   req_size = SzHalf;
        2'b10:   req_size = SzByte;
        default: type_ok = 1'b0;
      endcase
    end
    misaligned = ((req_size == SzWord) && (addr[1:0] != 2'b00)) ||
                 ((req_size == SzHalf) && addr[0]);
    req_err = (MemRead == MemWrite) || !type_ok || misaligned;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_err) begin
            state_d = StErr;
          end else if (MemRead) begin
            state_d = StLdRd;
          end else if (req_size == SzWord) begin
            state_d = StWr;
          end else begin
`ifdef LSU_BYTE_STROBE_EN
            state_d = StWr;
`else
            state_d = StRmwRd;
`endif
          end
        end
      end
      StLdRd:     state_d = StLdData;
      StRmwRd:    state_d = StRmwMerge;
      StRmwMerge: state_d = StWr;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      size_q  <= SzWord;
      sext_q  <= 1'b0;
      off_q   <= 2'b00;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q  <= req_size;
        sext_q  <= req_sext;
        off_q   <= addr[1:0];
        waddr_q <= addr[ADDR_W+1:2];
        wdata_q <= wdata;
      end
    end
  end

`ifndef LSU_BYTE_STROBE_EN
  // Read-modify-write merge: splice the store lane(s) into the word just read.
  logic [31:0] merged_q, merged_d;

  always_comb begin
    merged_d = mem_rdata;
    if (size_q == SzByte) begin
      merged_d[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged_d[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      merged_q <= '0;
    end else if (state_q == StRmwMerge) begin
      merged_q <= merged_d;
    end
  end
`endif

  // Load formatting from the SRAM output while in the data cycle.
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = mem_rdata[{off_q, 3'b000} +: 8];
    half_lane = mem_rdata[{off_q[1], 4'b0000} +: 16];
    rdata     = '0;
    if (state_q == StLdData) begin
      case (size_q)
        SzByte:  rdata = {{24{sext_q & byte_lane[7]}}, byte_lane};
        SzHalf:  rdata = {{16{sext_q & half_lane[15]}}, half_lane};
        default: rdata = mem_rdata;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    rsp_valid  = (state_q == StErr) || (state_q == StLdData) || (state_q == StWr);
    access_err = (state_q == StErr);
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    mem_addr   = waddr_q;
`ifdef LSU_BYTE_STROBE_EN
    mem_be     = 4'b0000;
`endif
    case (state_q)
      StLdRd, StRmwRd: mem_en = 1'b1;
      StWr: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
`ifdef LSU_BYTE_STROBE_EN
        case (size_q)
          SzByte: begin
            mem_wdata = {4{wdata_q[7:0]}};
            mem_be    = 4'b0001 << off_q;
          end
          SzHalf: begin
            mem_wdata = {2{wdata_q[15:0]}};
            mem_be    = off_q[1] ? 4'b1100 : 4'b0011;
          end
          default: begin
            mem_wdata = wdata_q;
            mem_be    = 4'b1111;
          end
        endcase
`else
        mem_wdata = (size_q == SzWord) ? wdata_q : merged_q;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed test-plan steps, mid-operation resets and
// randomized traffic checked against a byte-level reference memory model.
module tb_lsu_mem_port;
  localparam int unsigned AW     = 10;
  localparam int unsigned Region = 64;
`ifdef LSU_BYTE_STROBE_EN
  localparam bit Strobe = 1'b1;
`else
  localparam bit Strobe = 1'b0;
`endif

  logic          clk, rst_n;
  logic          req_valid, req_ready, MemRead, MemWrite;
  logic [1:0]    Store_Type;
  logic [2:0]    Load_Type;
  logic [31:0]   addr, wdata, rdata, mem_wdata, mem_rdata;
  logic          rsp_valid, access_err, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
`ifdef LSU_BYTE_STROBE_EN
  logic [3:0]    mem_be;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] sram    [1<<AW];
  logic [31:0] ref_mem [1<<AW];

  lsu_mem_port #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Store_Type(Store_Type),
    .Load_Type (Load_Type),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .access_err(access_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef LSU_BYTE_STROBE_EN
    ,
    .mem_be    (mem_be)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
`ifdef LSU_BYTE_STROBE_EN
        for (int i = 0; i < 4; i++) begin
          if (mem_be[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
`else
        sram[mem_addr] <= mem_wdata;
`endif
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes, 0 when the request has no legal type.
  function automatic int ref_size(input bit rd, input bit wr, input logic [1:0] st,
                                  input logic [2:0] lt);
    int s;
    s = 0;
    if (rd != wr) begin
      if (rd) begin
        case (lt)
          3'd0:       s = 4;
          3'd1, 3'd2: s = 2;
          3'd3, 3'd4: s = 1;
          default:    s = 0;
        endcase
      end else begin
        case (st)
          2'd0:    s = 4;
          2'd1:    s = 2;
          2'd2:    s = 1;
          default: s = 0;
        endcase
      end
    end
    return s;
  endfunction

  // Issue one request at a falling edge; leaves the bench at the falling edge where the
  // port is idle again, so consecutive calls exercise back-to-back accepts.
  task automatic do_req(input string tag, input bit rd, input bit wr, input logic [1:0] st,
                        input logic [2:0] lt, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got);
    int size, off, lat, exp_en, n_en, n_we, we_at, rsp_at, n_rdy, v;
    bit err, sgn;
    logic [31:0] exp_rd, exp_word, exp_wdata, sh, ae, w_data;
    logic [AW-1:0] idx, w_addr;
`ifdef LSU_BYTE_STROBE_EN
    logic [3:0] w_be, exp_be;
`endif
    size = ref_size(rd, wr, st, lt);
    off  = int'(a[1:0]);
    err  = (size == 0) || ((off % (size == 0 ? 1 : size)) != 0);
    idx  = a[AW+1:2];
    sgn  = rd && ((lt == 3'd1) || (lt == 3'd3));

    exp_word = ref_mem[idx];
    if (!err && wr) begin
      for (int i = 0; i < size; i++) exp_word[8*(off+i) +: 8] = wd[8*i +: 8];
    end
    exp_rd = '0;
    if (!err && rd) begin
      sh = ref_mem[idx] >> (8 * off);
      if (size == 4) begin
        exp_rd = ref_mem[idx];
      end else begin
        v = (size == 1) ? int'(sh & 32'hFF) : int'(sh & 32'hFFFF);
        if (sgn && v >= ((size == 1) ? 128 : 32768)) v -= (size == 1) ? 256 : 65536;
        exp_rd = 32'(v);
      end
    end
    if (err) begin
      lat = 1; exp_en = 0;
    end else if (rd) begin
      lat = 2; exp_en = 1;
    end else if (size == 4 || Strobe) begin
      lat = 1; exp_en = 1;
    end else begin
      lat = 3; exp_en = 2;
    end
    if (Strobe && size == 2)      exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
    else if (Strobe && size == 1) exp_wdata = (wd & 32'hFF) * 32'h0101_0101;
    else                          exp_wdata = exp_word;
`ifdef LSU_BYTE_STROBE_EN
    exp_be = (size == 4) ? 4'hF : 4'(((1 << size) - 1) << off);
    w_be   = '0;
`endif

    MemRead = rd; MemWrite = wr; Store_Type = st; Load_Type = lt;
    addr = a; wdata = wd; req_valid = 1'b1;
    check({tag, ":ready_at_accept"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    // Garbage while busy: must be ignored and must not disturb captured fields.
    MemRead = 1'($urandom); MemWrite = 1'($urandom); Store_Type = 2'($urandom);
    Load_Type = 3'($urandom); addr = $urandom; wdata = $urandom; req_valid = 1'b1;

    n_en = 0; n_we = 0; we_at = 0; rsp_at = 0; n_rdy = 0; got = '0; ae = '0;
    w_addr = '0; w_data = '0;
    for (int k = 1; k <= 6 && rsp_at == 0; k++) begin
      @(negedge clk);
      if (req_ready) n_rdy++;
      if (mem_en) n_en++;
      if (mem_en && mem_we) begin
        n_we++; we_at = k; w_addr = mem_addr; w_data = mem_wdata;
`ifdef LSU_BYTE_STROBE_EN
        w_be = mem_be;
`endif
      end
      if (rsp_valid) begin
        rsp_at = k; got = rdata; ae = 32'(access_err); req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;

    check({tag, ":latency"}, 32'(rsp_at), 32'(lat));
    check({tag, ":access_err"}, ae, 32'(err));
    check({tag, ":rdata"}, got, exp_rd);
    check({tag, ":mem_en_cycles"}, 32'(n_en), 32'(exp_en));
    check({tag, ":ready_while_busy"}, 32'(n_rdy), 32'd0);
    check({tag, ":write_count"}, 32'(n_we), 32'(!err && wr));
    if (!err && wr) begin
      check({tag, ":write_cycle"}, 32'(we_at), 32'(lat));
      check({tag, ":mem_addr"}, 32'(w_addr), 32'(idx));
      check({tag, ":mem_wdata"}, w_data, exp_wdata);
`ifdef LSU_BYTE_STROBE_EN
      check({tag, ":mem_be"}, 32'(w_be), 32'(exp_be));
`endif
    end

    @(negedge clk);
    check({tag, ":rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
    check({tag, ":ready_after"}, 32'(req_ready), 32'd1);
    if (!err && wr) begin
      ref_mem[idx] = exp_word;
      check({tag, ":sram_word"}, sram[idx], exp_word);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    check({tag, ":rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ":rdata"}, rdata, 32'd0);
    check({tag, ":access_err"}, 32'(access_err), 32'd0);
    check({tag, ":mem_en"}, 32'(mem_en), 32'd0);
    check({tag, ":mem_we"}, 32'(mem_we), 32'd0);
    check({tag, ":mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, ":mem_wdata"}, mem_wdata, 32'd0);
`ifdef LSU_BYTE_STROBE_EN
    check({tag, ":mem_be"}, 32'(mem_be), 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] got, a, wd;
    logic [1:0]  st;
    logic [2:0]  lt;
    bit rd, wr;
    int size, kind, w, off;

    rst_n = 1'b0; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Store_Type = '0; Load_Type = '0; addr = '0; wdata = '0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the working region so every load sees known data.
    for (int i = 0; i < Region; i++) begin
      do_req("fill", 1'b1 ^ 1'b1, 1'b1, 2'b00, 3'b000, 32'(i * 4), $urandom, got);
    end

    do_req("plan_sw", 1'b0, 1'b1, 2'b00, 3'b000, 32'h10, 32'hDEADBEEF, got);
    do_req("plan_lw", 1'b1, 1'b0, 2'b00, 3'b000, 32'h10, 32'h0, got);
    check("plan_lw_value", got, 32'hDEADBEEF);

    do_req("plan_sw20", 1'b0, 1'b1, 2'b00, 3'b000, 32'h20, 32'h80FF7F01, got);
    do_req("plan_lb", 1'b1, 1'b0, 2'b00, 3'b011, 32'h23, 32'h0, got);
    check("plan_lb_value", got, 32'hFFFFFF80);
    do_req("plan_lbu", 1'b1, 1'b0, 2'b00, 3'b100, 32'h22, 32'h0, got);
    check("plan_lbu_value", got, 32'h000000FF);
    do_req("plan_lh", 1'b1, 1'b0, 2'b00, 3'b001, 32'h22, 32'h0, got);
    check("plan_lh_value", got, 32'hFFFF80FF);
    do_req("plan_lhu", 1'b1, 1'b0, 2'b00, 3'b010, 32'h20, 32'h0, got);
    check("plan_lhu_value", got, 32'h00007F01);

    do_req("plan_sw30", 1'b0, 1'b1, 2'b00, 3'b000, 32'h30, 32'h11223344, got);
    do_req("plan_sb", 1'b0, 1'b1, 2'b10, 3'b000, 32'h31, 32'h000000AB, got);
    do_req("plan_sh", 1'b0, 1'b1, 2'b01, 3'b000, 32'h32, 32'h0000CAFE, got);
    do_req("plan_lw30", 1'b1, 1'b0, 2'b00, 3'b000, 32'h30, 32'h0, got);
    check("plan_merge_value", got, 32'hCAFEAB44);

    do_req("err_lw_mis", 1'b1, 1'b0, 2'b00, 3'b000, 32'h12, 32'h0, got);
    do_req("err_sh_mis", 1'b0, 1'b1, 2'b01, 3'b000, 32'h33, 32'h1234, got);
    do_req("err_st11", 1'b0, 1'b1, 2'b11, 3'b000, 32'h40, 32'h1234, got);
    do_req("err_both", 1'b1, 1'b1, 2'b00, 3'b000, 32'h40, 32'h1234, got);
    do_req("err_none", 1'b0, 1'b0, 2'b00, 3'b000, 32'h40, 32'h1234, got);
    do_req("err_lt5", 1'b1, 1'b0, 2'b00, 3'b101, 32'h40, 32'h0, got);
    do_req("err_lt7", 1'b1, 1'b0, 2'b00, 3'b111, 32'h44, 32'h0, got);

    // Reset during the load read cycle.
    MemRead = 1'b1; MemWrite = 1'b0; Load_Type = 3'b000; addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_ld:mem_en_before", 32'(mem_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_ld");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ld:no_late_rsp", 32'(rsp_valid), 32'd0);

`ifndef LSU_BYTE_STROBE_EN
    // Reset in the merge cycle must not leave a partial write behind.
    MemRead = 1'b0; MemWrite = 1'b1; Store_Type = 2'b10; addr = 32'h31; wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_rmw");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rmw:no_write", 32'(mem_we), 32'd0);
    check("rst_rmw:sram_intact", sram[12], 32'hCAFEAB44);
    do_req("rst_rmw_lw", 1'b1, 1'b0, 2'b00, 3'b000, 32'h30, 32'h0, got);
    check("rst_rmw_value", got, 32'hCAFEAB44);
`endif

    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 9));
      w    = int'($urandom_range(0, Region - 1));
      wd   = $urandom;
      if (kind == 0) begin
        rd = 1'($urandom); wr = 1'($urandom);
        st = 2'($urandom); lt = 3'($urandom);
        off = int'($urandom_range(0, 3));
      end else begin
        rd = 1'($urandom); wr = !rd;
        st = 2'($urandom_range(0, 2)); lt = 3'($urandom_range(0, 4));
        size = ref_size(rd, wr, st, lt);
        off = int'($urandom_range(0, 3)) & ~(size - 1);
      end
      a = ($urandom & 32'hFFFF_F000) | 32'(w * 4 + off);
      do_req($sformatf("rnd%0d", n), rd, wr, st, lt, a, wd, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
